// File: rtl/j_rxer_pkg.sv
// Shared UART2 receive definitions: state encoding, frame geometry and the
// parity-check helper used when the parity bit is sampled.
package j_rxer_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int DATA_BITS  = 8;
  localparam int PHASE_W    = $clog2(OVERSAMPLE);
  localparam int BITCNT_W   = $clog2(DATA_BITS);

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_BRKWAIT
  } rx_state_t;

  // Even mode wants data-plus-parity to hold an even count of ones, so any
  // odd total is an error; odd mode is the inverse.
  function automatic logic parity_error(input logic dataPar,
                                        input logic parBit,
                                        input logic evenMode);
    return (dataPar ^ parBit) ^ ~evenMode;
  endfunction

endpackage

// File: rtl/j_rxer_rxsync.sv
// Metastability synchroniser for an asynchronous pin. The chain resets to 1
// so an idle-high serial line looks idle straight out of reset.
module j_rxsync #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_en,
  input  logic i_async,
  output logic o_sync
);

  logic [STAGES-1:0] r_chain;

  // Shift the raw pin through the flop chain on each enabled clock.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_chain <= '1;
    end else if (i_en) begin
      r_chain <= {r_chain[STAGES-2:0], i_async};
    end
  end

  assign o_sync = r_chain[STAGES-1];

endmodule

// File: rtl/j_rxer.sv
// UART2 serial receiver: 16x oversampled start/data/parity/stop framing with
// sticky parity, framing, overrun and break flags for the register interface.
module j_rxer
  import j_rxer_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int MID_SAMPLE  = 7
) (
  input  logic                 sys_clk,
  input  logic                 reset,
  input  logic                 clk_ce,
  input  logic                 bx16,
  input  logic                 serin,
  input  logic                 rxpol,
  input  logic                 paren,
  input  logic                 even,
  input  logic                 u2drd,
  input  logic                 errclr,
  output logic [DATA_BITS-1:0] dout,
  output logic                 rbf,
  output logic                 perr,
  output logic                 ferr,
  output logic                 oerr,
  output logic                 rxbrk,
  output logic                 rxact
);

  localparam logic [PHASE_W-1:0]  MID_PHASE  = PHASE_W'(MID_SAMPLE);
  localparam logic [PHASE_W-1:0]  LAST_PHASE = PHASE_W'(OVERSAMPLE - 1);
  localparam logic [BITCNT_W-1:0] LAST_BIT   = BITCNT_W'(DATA_BITS - 1);

  rx_state_t            r_state;
  logic [PHASE_W-1:0]   r_phase;
  logic [BITCNT_W-1:0]  r_bitCnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_dataPar;
  logic                 r_parBit;
  logic                 r_parErr;
  logic [DATA_BITS-1:0] r_dout;
  logic                 r_rbf;
  logic                 r_perr;
  logic                 r_ferr;
  logic                 r_oerr;
  logic                 r_rxbrk;

  logic w_syncRx;
  logic w_rx;
  logic w_tick;
  logic w_mid;
  logic w_last;

  j_rxsync #(.STAGES(SYNC_STAGES)) u_sync (
    .i_clk   (sys_clk),
    .i_reset (reset),
    .i_en    (clk_ce),
    .i_async (serin),
    .o_sync  (w_syncRx)
  );

  assign w_rx   = w_syncRx ^ rxpol;
  assign w_tick = clk_ce & bx16;
  assign w_mid  = (r_phase == MID_PHASE);
  assign w_last = (r_phase == LAST_PHASE);

  // Frame FSM and datapath: advances only on oversample ticks, while the
  // host-side clears of rbf and the error flags act on every clock. Commit
  // updates are written last so they win over a same-cycle clear.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      r_state   <= RX_IDLE;
      r_phase   <= '0;
      r_bitCnt  <= '0;
      r_shift   <= '0;
      r_dataPar <= 1'b0;
      r_parBit  <= 1'b0;
      r_parErr  <= 1'b0;
      r_dout    <= '0;
      r_rbf     <= 1'b0;
      r_perr    <= 1'b0;
      r_ferr    <= 1'b0;
      r_oerr    <= 1'b0;
      r_rxbrk   <= 1'b0;
    end else begin
      if (u2drd) begin
        r_rbf <= 1'b0;
      end
      if (errclr) begin
        r_perr  <= 1'b0;
        r_ferr  <= 1'b0;
        r_oerr  <= 1'b0;
        r_rxbrk <= 1'b0;
      end
      if (w_tick) begin
        if (r_state == RX_IDLE) begin
          r_phase <= '0;
        end else begin
          r_phase <= r_phase + PHASE_W'(1);
        end
        unique case (r_state)
          RX_IDLE: begin
            if (!w_rx) begin
              r_state <= RX_START;
              r_phase <= PHASE_W'(1);
            end
          end
          RX_START: begin
            if (w_mid && w_rx) begin
              r_state <= RX_IDLE;
              r_phase <= '0;
            end else if (w_last) begin
              r_state   <= RX_DATA;
              r_bitCnt  <= '0;
              r_dataPar <= 1'b0;
            end
          end
          RX_DATA: begin
            if (w_mid) begin
              r_shift   <= {w_rx, r_shift[DATA_BITS-1:1]};
              r_dataPar <= r_dataPar ^ w_rx;
            end
            if (w_last) begin
              if (r_bitCnt == LAST_BIT) begin
                r_state <= paren ? RX_PARITY : RX_STOP;
              end else begin
                r_bitCnt <= r_bitCnt + BITCNT_W'(1);
              end
            end
          end
          RX_PARITY: begin
            if (w_mid) begin
              r_parBit <= w_rx;
              r_parErr <= parity_error(r_dataPar, w_rx, even);
            end
            if (w_last) begin
              r_state <= RX_STOP;
            end
          end
          RX_STOP: begin
            if (w_mid) begin
              r_dout  <= r_shift;
              r_rbf   <= 1'b1;
              r_perr  <= (r_perr & ~errclr) | (paren & r_parErr);
              r_ferr  <= (r_ferr & ~errclr) | ~w_rx;
              r_oerr  <= (r_oerr & ~errclr) | (r_rbf & ~u2drd);
              r_rxbrk <= (r_rxbrk & ~errclr)
                         | (~w_rx & (r_shift == '0) & (~paren | ~r_parBit));
              r_state <= w_rx ? RX_IDLE : RX_BRKWAIT;
              r_phase <= '0;
            end
          end
          RX_BRKWAIT: begin
            r_phase <= '0;
            if (w_rx) begin
              r_state <= RX_IDLE;
            end
          end
          default: begin
            r_state <= RX_IDLE;
            r_phase <= '0;
          end
        endcase
      end
    end
  end

  assign dout  = r_dout;
  assign rbf   = r_rbf;
  assign perr  = r_perr;
  assign ferr  = r_ferr;
  assign oerr  = r_oerr;
  assign rxbrk = r_rxbrk;
  assign rxact = (r_state != RX_IDLE);

endmodule

// File: tb/tb_j_rxer.sv
// Scoreboard bench for j_rxer: each frame sent pushes its expected byte and
// flag state, and the scenario task pops and compares once the frame commits.
module tb_j_rxer;

  logic       sys_clk = 1'b0;
  logic       reset, clk_ce, bx16, serin, rxpol, paren, even, u2drd, errclr;
  logic [7:0] dout;
  logic       rbf, perr, ferr, oerr, rxbrk, rxact;

  typedef struct {
    logic [7:0] data;
    logic [3:0] flags;
  } exp_t;

  exp_t     expQ[$];
  exp_t     e;
  int       errors    = 0;
  int       checks    = 0;
  int       stepCount = 0;
  int       divCnt    = 0;
  int       riseAt    = -1;
  bit       slowMode  = 1'b0;
  bit       tbPol     = 1'b0;
  bit       mRbf      = 1'b0;
  bit [3:0] mFlags    = 4'b0;

  j_rxer #(.SYNC_STAGES(2), .MID_SAMPLE(7)) dut (
    .sys_clk (sys_clk),
    .reset   (reset),
    .clk_ce  (clk_ce),
    .bx16    (bx16),
    .serin   (serin),
    .rxpol   (rxpol),
    .paren   (paren),
    .even    (even),
    .u2drd   (u2drd),
    .errclr  (errclr),
    .dout    (dout),
    .rbf     (rbf),
    .perr    (perr),
    .ferr    (ferr),
    .oerr    (oerr),
    .rxbrk   (rxbrk),
    .rxact   (rxact)
  );

  always #5 sys_clk = ~sys_clk;

  // In slow mode a tick lands only one cycle in four, with clk_ce and bx16
  // each high on other cycles too, so a lost gate shows up as a wrong rate.
  task automatic step();
    @(negedge sys_clk);
    stepCount++;
    if (slowMode) begin
      divCnt = (divCnt + 1) % 4;
      clk_ce = (divCnt % 2 == 0);
      bx16   = (divCnt < 2);
    end else begin
      clk_ce = 1'b1;
      bx16   = 1'b1;
    end
  endtask

  task automatic read_data();
    u2drd = 1'b1;
    step();
    u2drd = 1'b0;
    mRbf  = 1'b0;
  endtask

  task automatic clear_err();
    errclr = 1'b1;
    step();
    errclr = 1'b0;
    mFlags = 4'b0;
  endtask

  // Drives one frame (start, data LSB first, optional parity, stop) and
  // pushes the expected commit. Flag model order is {perr,ferr,oerr,rxbrk}.
  task automatic send_frame(input logic [7:0] data, input bit parBit,
                            input bit stopBit, input bit readAtCommit);
    logic [10:0] bits;
    int          n, cpb, ones, start;
    bit          pe, prevRbf;
    exp_t        x;
    n    = paren ? 11 : 10;
    bits = paren ? {stopBit, parBit, data, 1'b0} : {1'b0, stopBit, data, 1'b0};
    cpb  = slowMode ? 64 : 16;
    ones = $countones(data) + int'(parBit);
    pe   = paren && (even ? (ones % 2 != 0) : (ones % 2 == 0));
    mFlags[3] = mFlags[3] | pe;
    mFlags[2] = mFlags[2] | !stopBit;
    mFlags[1] = mFlags[1] | (mRbf && !readAtCommit);
    mFlags[0] = mFlags[0] | (!stopBit && data == 8'h00 && (!paren || !parBit));
    mRbf    = 1'b1;
    x.data  = data;
    x.flags = mFlags;
    expQ.push_back(x);
    riseAt  = -1;
    start   = stepCount;
    prevRbf = rbf;
    for (int b = 0; b < n; b++) begin
      serin = bits[b] ^ tbPol;
      for (int k = 0; k < cpb; k++) begin
        if (readAtCommit) u2drd = (b == n - 1 && k == 9);
        step();
        if (riseAt < 0 && rbf && !prevRbf) riseAt = stepCount - start;
        prevRbf = rbf;
      end
    end
    u2drd = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) step();
    checks++;
    if ({dout, rbf, rxact} !== 10'b0) begin
      errors++;
      $display("[TB] FAIL reset_data: got dout=%h rbf=%b rxact=%b want 0", dout, rbf, rxact);
    end
    checks++;
    if ({perr, ferr, oerr, rxbrk} !== 4'b0) begin
      errors++;
      $display("[TB] FAIL reset_flags: got %b want 0000", {perr, ferr, oerr, rxbrk});
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_basic();
    send_frame(8'h55, 1'b0, 1'b1, 1'b0);
    e = expQ.pop_front();
    checks++;
    if (dout !== e.data) begin
      errors++;
      $display("[TB] FAIL basic_dout: got %h want %h", dout, e.data);
    end
    checks++;
    if ({rbf, perr, ferr, oerr, rxbrk} !== {1'b1, e.flags}) begin
      errors++;
      $display("[TB] FAIL basic_flags: got %b want %b", {rbf, perr, ferr, oerr, rxbrk}, {1'b1, e.flags});
    end
    // Start is seen 2 syncs + 1 tick in, stop is sampled at phase 7 of bit 9.
    checks++;
    if (riseAt !== 154) begin
      errors++;
      $display("[TB] FAIL basic_latency: got %0d want 154", riseAt);
    end
    read_data();
    checks++;
    if (rbf !== 1'b0) begin
      errors++;
      $display("[TB] FAIL basic_read: got rbf=%b want 0", rbf);
    end
  endtask

  task automatic test_false_start();
    serin = 1'b0;
    repeat (5) step();
    serin = 1'b1;
    repeat (30) step();
    checks++;
    if ({rxact, rbf, perr, ferr, oerr, rxbrk} !== 6'b0) begin
      errors++;
      $display("[TB] FAIL false_start: got %b want 000000", {rxact, rbf, perr, ferr, oerr, rxbrk});
    end
    send_frame(8'hA3, 1'b0, 1'b1, 1'b0);
    e = expQ.pop_front();
    checks++;
    if (dout !== e.data || rbf !== 1'b1) begin
      errors++;
      $display("[TB] FAIL after_false_start: got %h/%b want %h/1", dout, rbf, e.data);
    end
    read_data();
  endtask

  task automatic test_parity();
    paren = 1'b1;
    even  = 1'b1;
    send_frame(8'h07, 1'b0, 1'b1, 1'b0);
    e = expQ.pop_front();
    checks++;
    if (dout !== e.data || {perr, ferr, oerr, rxbrk} !== e.flags) begin
      errors++;
      $display("[TB] FAIL parity_bad: got %h/%b want %h/%b", dout, {perr, ferr, oerr, rxbrk}, e.data, e.flags);
    end
    read_data();
    send_frame(8'h07, 1'b1, 1'b1, 1'b0);
    e = expQ.pop_front();
    checks++;
    if ({perr, ferr, oerr, rxbrk} !== e.flags) begin
      errors++;
      $display("[TB] FAIL parity_sticky: got %b want %b", {perr, ferr, oerr, rxbrk}, e.flags);
    end
    read_data();
    clear_err();
    checks++;
    if ({perr, ferr, oerr, rxbrk} !== mFlags) begin
      errors++;
      $display("[TB] FAIL parity_clear: got %b want %b", {perr, ferr, oerr, rxbrk}, mFlags);
    end
    paren = 1'b0;
    even  = 1'b0;
  endtask

  task automatic test_overrun();
    send_frame(8'h12, 1'b0, 1'b1, 1'b0);
    e = expQ.pop_front();
    send_frame(8'h34, 1'b0, 1'b1, 1'b0);
    e = expQ.pop_front();
    checks++;
    if (dout !== e.data || {perr, ferr, oerr, rxbrk} !== e.flags) begin
      errors++;
      $display("[TB] FAIL overrun: got %h/%b want %h/%b", dout, {perr, ferr, oerr, rxbrk}, e.data, e.flags);
    end
    read_data();
    clear_err();
    send_frame(8'h12, 1'b0, 1'b1, 1'b0);
    e = expQ.pop_front();
    send_frame(8'h34, 1'b0, 1'b1, 1'b1);
    e = expQ.pop_front();
    checks++;
    if (dout !== e.data || rbf !== 1'b1 || {perr, ferr, oerr, rxbrk} !== e.flags) begin
      errors++;
      $display("[TB] FAIL read_at_commit: got %h/%b/%b want %h/1/%b", dout, rbf, {perr, ferr, oerr, rxbrk}, e.data, e.flags);
    end
    read_data();
  endtask

  task automatic test_break();
    send_frame(8'h00, 1'b0, 1'b0, 1'b0);
    repeat (160) step();
    e = expQ.pop_front();
    checks++;
    if (dout !== e.data || {perr, ferr, oerr, rxbrk} !== e.flags) begin
      errors++;
      $display("[TB] FAIL break_flags: got %h/%b want %h/%b", dout, {perr, ferr, oerr, rxbrk}, e.data, e.flags);
    end
    checks++;
    if (rxact !== 1'b1) begin
      errors++;
      $display("[TB] FAIL break_hold: got rxact=%b want 1", rxact);
    end
    serin = 1'b1;
    repeat (20) step();
    checks++;
    if (rxact !== 1'b0) begin
      errors++;
      $display("[TB] FAIL break_release: got rxact=%b want 0", rxact);
    end
    read_data();
    clear_err();
    send_frame(8'h5A, 1'b0, 1'b1, 1'b0);
    e = expQ.pop_front();
    checks++;
    if (dout !== e.data || {perr, ferr, oerr, rxbrk} !== e.flags) begin
      errors++;
      $display("[TB] FAIL after_break: got %h/%b want %h/%b", dout, {perr, ferr, oerr, rxbrk}, e.data, e.flags);
    end
    read_data();
  endtask

  task automatic test_polarity();
    tbPol = 1'b1;
    serin = 1'b0;
    rxpol = 1'b1;
    repeat (40) step();
    send_frame(8'hC3, 1'b0, 1'b1, 1'b0);
    e = expQ.pop_front();
    checks++;
    if (dout !== e.data || {perr, ferr, oerr, rxbrk} !== e.flags) begin
      errors++;
      $display("[TB] FAIL polarity: got %h/%b want %h/%b", dout, {perr, ferr, oerr, rxbrk}, e.data, e.flags);
    end
    read_data();
    tbPol = 1'b0;
    serin = 1'b1;
    rxpol = 1'b0;
    repeat (40) step();
  endtask

  task automatic test_slow_tick();
    slowMode = 1'b1;
    repeat (8) step();
    send_frame(8'h96, 1'b0, 1'b1, 1'b0);
    e = expQ.pop_front();
    checks++;
    if (dout !== e.data || rbf !== 1'b1 || {perr, ferr, oerr, rxbrk} !== e.flags) begin
      errors++;
      $display("[TB] FAIL slow_tick: got %h/%b/%b want %h/1/%b", dout, rbf, {perr, ferr, oerr, rxbrk}, e.data, e.flags);
    end
    read_data();
    slowMode = 1'b0;
    repeat (4) step();
  endtask

  task automatic test_reset_mid_frame();
    serin = 1'b0;
    repeat (16) step();
    serin = 1'b1;
    repeat (40) step();
    checks++;
    if (rxact !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mid_frame_active: got rxact=%b want 1", rxact);
    end
    reset = 1'b1;
    repeat (2) step();
    mRbf   = 1'b0;
    mFlags = 4'b0;
    checks++;
    if ({dout, rbf, perr, ferr, oerr, rxbrk, rxact} !== 14'b0) begin
      errors++;
      $display("[TB] FAIL mid_frame_reset: got dout=%h status=%b want 0", dout, {rbf, perr, ferr, oerr, rxbrk, rxact});
    end
    reset = 1'b0;
    repeat (5) step();
    send_frame(8'h3C, 1'b0, 1'b1, 1'b0);
    e = expQ.pop_front();
    checks++;
    if (dout !== e.data || rbf !== 1'b1 || {perr, ferr, oerr, rxbrk} !== e.flags) begin
      errors++;
      $display("[TB] FAIL after_reset: got %h/%b/%b want %h/1/%b", dout, rbf, {perr, ferr, oerr, rxbrk}, e.data, e.flags);
    end
  endtask

  // Run every scenario in order, then report.
  initial begin
    reset  = 1'b1;
    clk_ce = 1'b1;
    bx16   = 1'b1;
    serin  = 1'b1;
    rxpol  = 1'b0;
    paren  = 1'b0;
    even   = 1'b0;
    u2drd  = 1'b0;
    errclr = 1'b0;
    test_reset();
    test_basic();
    test_false_start();
    test_parity();
    test_overrun();
    test_break();
    test_polarity();
    test_slow_tick();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #500000;
    $display("[TB] FAIL timeout: got no completion want completion");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/j_rxer.md
Name: j_rxer

Overview:
- UART2 serial receiver; the receive counterpart of the UART2 transmitter.
- Oversamples `serin` at 16x the bit rate, detects and validates the start bit, and shifts in 8 data bits LSB first.
- Optionally checks even/odd parity, then checks the stop bit.
- Presents the byte plus status flags (rbf, perr, ferr, oerr, rxbrk) to the UART2 register interface.

Parameters:
- SYNC_STAGES, 2, number of flops in the serin metastability synchroniser (min 2).
- MID_SAMPLE, 7, oversample phase (0-15) at which each bit is sampled.

Ports:
- sys_clk  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- clk_ce  in  1  one-cycle strobe marking a UART2 core-clock edge; all logic advances only when it is 1.
- bx16  in  1  16x baud enable from the baud divider; an oversample tick is clk_ce & bx16.
- serin  in  1  raw serial input pin, asynchronous.
- rxpol  in  1  1 = line inverted; the line is XORed with rxpol after the synchroniser.
- paren  in  1  parity bit present and checked.
- even  in  1  1 = even parity, 0 = odd parity.
- u2drd  in  1  one-cycle data-register read strobe; clears rbf.
- errclr  in  1  one-cycle strobe; clears perr, ferr, oerr and rxbrk.
- dout  out  8  last received byte.
- rbf  out  1  receive buffer full.
- perr  out  1  parity error (sticky).
- ferr  out  1  framing error (sticky).
- oerr  out  1  overrun error (sticky).
- rxbrk  out  1  break detected (sticky).
- rxact  out  1  frame in progress (state != IDLE).

Behaviour:
- Reset (synchronous, active-high):
  - state = IDLE; phase and bit counters = 0.
  - Synchroniser flops = 1 (idle line).
  - Shift register = 0.
  - All outputs = 0.
  - Reset mid-frame abandons the frame and sets no flags.
- Line conditioning: `rx = sync(serin) ^ rxpol`. Idle level of rx is 1.
- All state and counter updates below occur only on a tick (clk_ce & bx16). Flag clears via u2drd/errclr act on any sys_clk cycle.
- Phase counter: 4 bits, wraps 15 -> 0.
- IDLE:
  - phase held at 0.
  - rx == 0 on a tick -> START, phase = 1.
- START:
  - At phase == MID_SAMPLE: rx == 1 -> IDLE (false start, no flags); rx == 0 -> continue.
  - At phase 15 -> DATA, bit counter = 0.
- DATA:
  - At phase == MID_SAMPLE: shift right, new bit into [7]; running parity ^= rx.
  - At phase 15: if bit counter == 7 -> PARITY when paren = 1, else STOP; otherwise increment the bit counter.
- PARITY:
  - At phase == MID_SAMPLE: computed error = (parity of data ^ rx) ^ ~even. Even mode expects the total count of 1s to be even.
  - At phase 15 -> STOP.
- STOP: at phase == MID_SAMPLE, commit the frame:
  - dout = shift register.
  - perr |= parity error (only when paren).
  - ferr |= ~rx.
  - rxbrk |= (~rx & shift == 0 & (paren ? parity bit == 0 : 1)).
  - oerr |= rbf & ~u2drd in that cycle.
  - rbf = 1.
  - Next state: rx == 1 -> IDLE; rx == 0 -> BRKWAIT.
- BRKWAIT: stay until rx == 1 on a tick, then IDLE. No start detection while in BRKWAIT.
- Overrun: the new byte overwrites dout and oerr sets.
- Simultaneous events:
  - u2drd in the same cycle as a commit: rbf stays 1, no oerr.
  - errclr in the same cycle as a commit: commit flags win.
- Latency: dout/rbf valid on the sys_clk cycle after the tick that samples the stop bit. This is mid-stop-bit, so the next start edge is caught without a gap.
- Flags are sticky until errclr or reset. rbf clears only on u2drd or reset.

Decomposition:
- Shared package (uart2 definitions):
  - rx state encoding: IDLE, START, DATA, PARITY, STOP, BRKWAIT.
  - Constants: OVERSAMPLE = 16, DATA_BITS = 8.
- One natural sub-module, `j_rxsync`: a parameterised SYNC_STAGES flop chain with reset value 1. It is reusable for other async pins.
- The remainder is a single FSM plus datapath.

Test Plan:
- Frame 0x55, paren = 0, rxpol = 0, bx16 = 1 every cycle, clk_ce = 1 -> dout = 0x55, rbf = 1 exactly 1 cycle after stop sample, all flags 0; u2drd -> rbf = 0.
- serin low for 5 ticks then high -> returns to IDLE, rbf = 0, no flags; then a valid 0xA3 frame -> dout = 0xA3.
- paren = 1, even = 1, byte 0x07 with parity bit 0 -> perr = 1. Same byte with parity bit 1 -> perr stays 1 until errclr, then 0.
- 0x12 received, not read, then 0x34 received -> dout = 0x34, oerr = 1. Repeat with u2drd pulsed in the exact commit cycle -> oerr = 0, rbf = 1.
- serin held 0 for 20 bit times -> dout = 0x00, ferr = 1, rxbrk = 1, state held in BRKWAIT; line high, then 0x5A -> dout = 0x5A.
- rxpol = 1 with inverted 0xC3 frame -> dout = 0xC3. Reset asserted mid-DATA -> all outputs 0, next frame received correctly.
